// File: rtl/fir_sequencer.sv
// Sequencer wrapped around an external FIR engine: zero-flushes the taps, discards warm-up
// results, then streams samples in and decimated, saturated results out through a 2-deep FIFO.
module fir_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int TAP_NUM    = 64,
    parameter int DECIM      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  fir_in_valid,
    output logic [DATA_WIDTH-1:0] fir_in_data,
    input  logic                  fir_out_valid,
    input  logic [ACC_WIDTH-1:0]  fir_out_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  overflow
);

    localparam int TAP_CW = $clog2(TAP_NUM + 1);
    localparam int DEC_CW = $clog2(DECIM + 1);
    localparam int HI_W   = ACC_WIDTH - DATA_WIDTH + 1;
    localparam logic [TAP_CW-1:0] TAP_LAST = TAP_CW'(TAP_NUM - 1);
    localparam logic [DEC_CW-1:0] DEC_LAST = DEC_CW'(DECIM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        WARM  = 2'd2,
        RUN   = 2'd3
    } state_e;

    // The value fits when every bit from the result's sign bit upwards is a sign copy.
    function automatic logic [DATA_WIDTH-1:0] saturate(input logic [ACC_WIDTH-1:0] value);
        logic [HI_W-1:0]       hi;
        logic [DATA_WIDTH-1:0] result;
        hi = value[ACC_WIDTH-1:DATA_WIDTH-1];
        if ((hi == {HI_W{1'b0}}) || (hi == {HI_W{1'b1}})) begin
            result = value[DATA_WIDTH-1:0];
        end else if (value[ACC_WIDTH-1]) begin
            result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return result;
    endfunction

    state_e                state_q, state_d;
    logic [TAP_CW-1:0]     flush_cnt_q, flush_cnt_d;
    logic [TAP_CW-1:0]     discard_cnt_q, discard_cnt_d;
    logic [DEC_CW-1:0]     decim_cnt_q, decim_cnt_d;
    logic                  fir_in_valid_q, fir_in_valid_d;
    logic [DATA_WIDTH-1:0] fir_in_data_q, fir_in_data_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0] fifo_mem_q [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  accept_s;
    logic                  keep_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [DATA_WIDTH-1:0] sat_s;

    assign s_ready      = (state_q == RUN) && enable;
    assign accept_s     = s_ready && s_valid;
    assign keep_s       = (state_q == RUN) && fir_out_valid && (decim_cnt_q == DEC_LAST);
    assign sat_s        = saturate(fir_out_data);
    assign fir_in_valid = fir_in_valid_q;
    assign fir_in_data  = fir_in_data_q;
    assign busy         = busy_q;
    assign overflow     = overflow_q;
    assign m_valid      = (count_q != 2'd0);
    assign m_data       = fifo_mem_q[rd_ptr_q];

    // Next-state, phase counters and the registered FIR-input strobe.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        discard_cnt_d = discard_cnt_q;
        decim_cnt_d   = decim_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d       = FLUSH;
                    flush_cnt_d   = {TAP_CW{1'b0}};
                    discard_cnt_d = {TAP_CW{1'b0}};
                    decim_cnt_d   = {DEC_CW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (flush_cnt_q == TAP_LAST) begin
                    state_d = WARM;
                end else begin
                    flush_cnt_d = flush_cnt_q + TAP_CW'(1);
                end
            end
            WARM: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (fir_out_valid) begin
                    if (discard_cnt_q == TAP_LAST) begin
                        state_d = RUN;
                    end else begin
                        discard_cnt_d = discard_cnt_q + TAP_CW'(1);
                    end
                end else begin
                    state_d = WARM;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
                // Results arriving on the cycle enable drops still count toward decimation.
                if (fir_out_valid) begin
                    if (decim_cnt_q == DEC_LAST) begin
                        decim_cnt_d = {DEC_CW{1'b0}};
                    end else begin
                        decim_cnt_d = decim_cnt_q + DEC_CW'(1);
                    end
                end else begin
                    decim_cnt_d = decim_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        fir_in_valid_d = (state_d == FLUSH) || accept_s;
        if (accept_s) begin
            fir_in_data_d = s_data;
        end else begin
            fir_in_data_d = {DATA_WIDTH{1'b0}};
        end
        busy_d = (state_d != IDLE);
    end

    // Output FIFO bookkeeping; a full FIFO still accepts a write when the head pops this cycle.
    always_comb begin
        full_s     = (count_q == 2'd2);
        pop_s      = m_valid && m_ready;
        push_s     = keep_s && (!full_s || pop_s);
        drop_s     = keep_s && full_s && !pop_s;
        overflow_d = overflow_q || drop_s;
        wr_ptr_d   = push_s ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d   = pop_s ? ~rd_ptr_q : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Control state, counters and FIR-side registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            flush_cnt_q    <= {TAP_CW{1'b0}};
            discard_cnt_q  <= {TAP_CW{1'b0}};
            decim_cnt_q    <= {DEC_CW{1'b0}};
            fir_in_valid_q <= 1'b0;
            fir_in_data_q  <= {DATA_WIDTH{1'b0}};
            busy_q         <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            discard_cnt_q  <= discard_cnt_d;
            decim_cnt_q    <= decim_cnt_d;
            fir_in_valid_q <= fir_in_valid_d;
            fir_in_data_q  <= fir_in_data_d;
            busy_q         <= busy_d;
            overflow_q     <= overflow_d;
        end
    end

    // FIFO storage and pointers; contents are independent of the control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= sat_s;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the sample width.
REQ-002 The block SHALL have parameter ACC_WIDTH, default 32, giving the width of the scaled FIR result.
REQ-003 The block SHALL have parameter TAP_NUM, default 64, giving the number of filter taps.
REQ-004 The block SHALL have parameter DECIM, default 4, giving the output decimation factor (legal range 1..256).
REQ-005 Ports SHALL be exactly as follows; there is one clock, and reset is asynchronous and active-high:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  run request
- s_valid  in  1  upstream sample valid
- s_data  in  DATA_WIDTH  upstream sample, signed
- s_ready  out  1  upstream accept
- fir_in_valid  out  1  sample strobe to FIR
- fir_in_data  out  DATA_WIDTH  sample to FIR
- fir_out_valid  in  1  FIR result strobe
- fir_out_data  in  ACC_WIDTH  FIR result, signed, already scaled
- m_valid  out  1  output sample valid
- m_data  out  DATA_WIDTH  output sample, signed
- m_ready  in  1  downstream accept
- busy  out  1  state is not IDLE
- overflow  out  1  sticky: result dropped

Function
REQ-006 The FSM SHALL have four states: IDLE, FLUSH, WARM and RUN.
REQ-007 IDLE: s_ready=0 and fir_in_valid=0; when enable=1, the next state SHALL be FLUSH, with flush_cnt=0, discard_cnt=0 and decim_cnt=0.
REQ-008 FLUSH: the block SHALL drive fir_in_valid=1 and fir_in_data=0 on each of TAP_NUM consecutive cycles, then enter WARM.
REQ-009 WARM: fir_in_valid=0 and s_ready=0; the block SHALL count fir_out_valid pulses and discard each one, then enter RUN in the cycle after the TAP_NUM-th discard.
REQ-010 RUN: s_ready SHALL equal enable; on s_valid&&s_ready in cycle T, fir_in_valid SHALL be 1 and fir_in_data SHALL equal s_data in cycle T+1 (both registered); otherwise fir_in_valid=0.
REQ-011 When enable=0 in FLUSH, WARM or RUN, the next state SHALL be IDLE; the flush and discard counts are abandoned.
REQ-012 A fir_out_valid received in IDLE, FLUSH or WARM SHALL NOT reach the output FIFO.
REQ-013 In RUN, each fir_out_valid SHALL advance decim_cnt modulo DECIM; the result SHALL be kept only when decim_cnt==DECIM-1 before the increment, so the first kept result is the DECIM-th result.
REQ-014 A kept result SHALL be saturated to signed DATA_WIDTH: values above 2^(DATA_WIDTH-1)-1 clamp to 32767, and values below -2^(DATA_WIDTH-1) clamp to -32768; all other values pass unchanged.
REQ-015 The output SHALL be a 2-entry FIFO: m_valid=!empty; m_data=head; pop on m_valid&&m_ready.
REQ-016 A kept result in the same cycle as a pop SHALL be written, including when the FIFO is full.
REQ-017 A kept result while the FIFO is full with no pop SHALL be dropped, and overflow SHALL be set to 1; overflow clears only on rst.
REQ-018 FIFO contents SHALL survive IDLE/enable toggles and remain drainable.
REQ-019 busy SHALL equal (state!=IDLE), registered.
REQ-020 All counters SHALL be wide enough that TAP_NUM and DECIM do not wrap.

Reset
REQ-021 While rst=1, the block SHALL be in state IDLE, with all counters=0, FIFO empty and all outputs 0: s_ready, fir_in_valid, fir_in_data, m_valid, m_data, busy and overflow.
REQ-022 Reset SHALL take effect asynchronously, mid-operation in any state.
REQ-023 After rst deasserts, the block SHALL stay in IDLE until the first clock edge with enable=1.

Verification
REQ-024 Start-up: enable=1 from reset -> exactly 64 fir_in_valid cycles with fir_in_data=0; WARM until 64 fir_out_valid pulses; s_ready=1 in the next cycle.
REQ-025 Decimation: RUN, DECIM=4, FIR results 10,20,...,80 -> m_data 40 then 80; no other outputs.
REQ-026 Saturation: kept results 0x0001_0000, -70000 and 1234 -> m_data 32767, -32768 and 1234.
REQ-027 Backpressure: m_ready=0 with 3 kept results -> m_valid=1, FIFO holds the first two, overflow=1; with m_ready=1 and a simultaneous kept result on a full FIFO -> written, no overflow.
REQ-028 Abort: enable drops at flush cycle 30 -> IDLE next cycle; re-enable -> a fresh 64-cycle flush; results in flight during WARM are discarded.
REQ-029 Reset mid-RUN with FIFO=2 -> all outputs 0 immediately (before the next clk edge), and the FIFO is empty.
